palette_lookup: RTL and testbench



---
 rtl/palette_lookup.sv | 94 +++++++++
 tb/tb_palette_lookup.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_lookup.sv
// Palette lookup stage: index stream -> palette RAM -> colour FIFO, with FIFO backpressure.
// Optional PALETTE_WRITE_FORWARD_EN forwards a same-edge palette write into the lookup result.
`timescale 1ns/1ps

module palette_lookup #(
  parameter int INDEX_WIDTH = 8,
  parameter int COLOR_WIDTH = 24
) (
  input  logic                   clk_pipe,
  input  logic                   reset,
  input  logic                   inValid,
  input  logic [INDEX_WIDTH-1:0] inIndex,
  output logic                   inReady,
  input  logic                   palWriteEn,
  input  logic [INDEX_WIDTH-1:0] palAddr,
  input  logic [COLOR_WIDTH-1:0] palData,
  input  logic                   fifoFull,
  output logic                   writeEn,
  output logic [COLOR_WIDTH-1:0] dataOut,
  output logic [15:0]            pixelCount
);

  localparam int PAL_DEPTH = 2 ** INDEX_WIDTH;

  logic [COLOR_WIDTH-1:0] palette [0:PAL_DEPTH-1];

  logic                   s1Valid;
  logic [INDEX_WIDTH-1:0] s1Index;
  logic                   s2Valid;
  logic [COLOR_WIDTH-1:0] s2Color;

  logic                   s1Adv;
  logic                   s2Adv;
  logic [COLOR_WIDTH-1:0] lookupColor;

  // A FIFO write retires S2 in the same cycle, so S2 can refill while draining.
  assign writeEn = s2Valid && !fifoFull;
  assign s2Adv   = s1Valid && (!s2Valid || !fifoFull);
  assign inReady = !s1Valid || s2Adv;
  assign s1Adv   = inValid && inReady;
  assign dataOut = s2Valid ? s2Color : '0;

  // Palette storage has no reset; its contents survive a pipeline reset.
  always_ff @(posedge clk_pipe) begin
    if (palWriteEn) begin
      palette[palAddr] <= palData;
    end
  end

`ifdef PALETTE_WRITE_FORWARD_EN
  always_comb begin
    lookupColor = palette[s1Index];
    if (palWriteEn && (palAddr == s1Index)) begin
      lookupColor = palData;
    end
  end
`else
  assign lookupColor = palette[s1Index];
`endif

  always_ff @(posedge clk_pipe) begin
    if (reset) begin
      s1Valid <= 1'b0;
      s1Index <= '0;
    end else if (s1Adv) begin
      s1Valid <= 1'b1;
      s1Index <= inIndex;
    end else if (s2Adv) begin
      s1Valid <= 1'b0;
    end
  end

  // s2Color is the RAM output register; it only loads on s2Adv and holds while stalled.
  always_ff @(posedge clk_pipe) begin
    if (reset) begin
      s2Valid <= 1'b0;
      s2Color <= '0;
    end else if (s2Adv) begin
      s2Valid <= 1'b1;
      s2Color <= lookupColor;
    end else if (writeEn) begin
      s2Valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_pipe) begin
    if (reset) begin
      pixelCount <= '0;
    end else if (writeEn) begin
      pixelCount <= pixelCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_palette_lookup.sv
// Directed self-checking bench for palette_lookup; expected values are hand-derived constants.
`timescale 1ns/1ps

module tb_palette_lookup;

  logic        clk_pipe = 1'b0;
  logic        reset;
  logic        inValid;
  logic [7:0]  inIndex;
  logic        inReady;
  logic        palWriteEn;
  logic [7:0]  palAddr;
  logic [23:0] palData;
  logic        fifoFull;
  logic        writeEn;
  logic [23:0] dataOut;
  logic [15:0] pixelCount;

  int checks = 0;
  int failures = 0;

  palette_lookup #(.INDEX_WIDTH(8), .COLOR_WIDTH(24)) dut (
    .clk_pipe  (clk_pipe),
    .reset     (reset),
    .inValid   (inValid),
    .inIndex   (inIndex),
    .inReady   (inReady),
    .palWriteEn(palWriteEn),
    .palAddr   (palAddr),
    .palData   (palData),
    .fifoFull  (fifoFull),
    .writeEn   (writeEn),
    .dataOut   (dataOut),
    .pixelCount(pixelCount)
  );

  always #5 clk_pipe = ~clk_pipe;

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk_pipe);
    #1;
  endtask

  task automatic write_pal(input logic [7:0] addr, input logic [23:0] data);
    palWriteEn = 1'b1;
    palAddr    = addr;
    palData    = data;
    tick();
    palWriteEn = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (writeEn !== 1'b0) begin failures++; $display("[TB] FAIL reset_writeEn got=%b exp=0", writeEn); end
    checks++;
    if (dataOut !== 24'h0) begin failures++; $display("[TB] FAIL reset_dataOut got=%h exp=000000", dataOut); end
    checks++;
    if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_inReady got=%b exp=1", inReady); end
    checks++;
    if (pixelCount !== 16'd0) begin failures++; $display("[TB] FAIL reset_pixelCount got=%0d exp=0", pixelCount); end
  endtask

  task automatic test_basic_stream();
    write_pal(8'h05, 24'h112233);
    write_pal(8'hFF, 24'hABCDEF);
    inValid = 1'b1;
    inIndex = 8'h05;
    #1;
    checks++;
    if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL basic_ready got=%b exp=1", inReady); end
    tick();
    inIndex = 8'hFF;
    #1;
    checks++;
    if (writeEn !== 1'b0) begin failures++; $display("[TB] FAIL basic_latency got=%b exp=0", writeEn); end
    tick();
    inIndex = 8'h05;
    #1;
    checks++;
    if (writeEn !== 1'b1 || dataOut !== 24'h112233) begin
      failures++; $display("[TB] FAIL basic_pix0 got we=%b data=%h exp we=1 data=112233", writeEn, dataOut);
    end
    tick();
    inValid = 1'b0;
    #1;
    checks++;
    if (writeEn !== 1'b1 || dataOut !== 24'hABCDEF) begin
      failures++; $display("[TB] FAIL basic_pix1 got we=%b data=%h exp we=1 data=abcdef", writeEn, dataOut);
    end
    tick();
    #1;
    checks++;
    if (writeEn !== 1'b1 || dataOut !== 24'h112233) begin
      failures++; $display("[TB] FAIL basic_pix2 got we=%b data=%h exp we=1 data=112233", writeEn, dataOut);
    end
    tick();
    #1;
    checks++;
    if (writeEn !== 1'b0 || dataOut !== 24'h0) begin
      failures++; $display("[TB] FAIL basic_idle got we=%b data=%h exp we=0 data=000000", writeEn, dataOut);
    end
    checks++;
    if (pixelCount !== 16'd3) begin failures++; $display("[TB] FAIL basic_count got=%0d exp=3", pixelCount); end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int recv = 0;
    int c = 0;
    for (int i = 0; i < 10; i++) begin
      write_pal(8'h40 + 8'(i), 24'hC0F000 + 24'(i));
    end
    while (recv < 10 && c < 60) begin
      inValid  = (sent < 10);
      inIndex  = 8'h40 + 8'(sent);
      fifoFull = (c >= 3 && c <= 8);
      #1;
      if (fifoFull && writeEn) begin
        checks++; failures++;
        $display("[TB] FAIL bp_write_when_full cycle=%0d got we=1 exp we=0", c);
      end
      if (c == 5) begin
        checks++;
        if (inReady !== 1'b0) begin failures++; $display("[TB] FAIL bp_inReady got=%b exp=0", inReady); end
      end
      if (writeEn) begin
        checks++;
        if (dataOut !== 24'hC0F000 + 24'(recv)) begin
          failures++;
          $display("[TB] FAIL bp_order pix=%0d got=%h exp=%h", recv, dataOut, 24'hC0F000 + 24'(recv));
        end
        recv++;
      end
      if (inValid && inReady) sent++;
      tick();
      c++;
    end
    inValid  = 1'b0;
    fifoFull = 1'b0;
    #1;
    checks++;
    if (recv !== 10 || writeEn !== 1'b0) begin
      failures++; $display("[TB] FAIL bp_count got recv=%0d we=%b exp recv=10 we=0", recv, writeEn);
    end
    checks++;
    if (pixelCount !== 16'd13) begin failures++; $display("[TB] FAIL bp_pixelCount got=%0d exp=13", pixelCount); end
  endtask

  task automatic test_collision();
    logic [23:0] expColor;
`ifdef PALETTE_WRITE_FORWARD_EN
    expColor = 24'h0000FF;
`else
    expColor = 24'h000001;
`endif
    write_pal(8'h20, 24'h000001);
    inValid = 1'b1;
    inIndex = 8'h20;
    tick();
    inValid    = 1'b0;
    palWriteEn = 1'b1;
    palAddr    = 8'h20;
    palData    = 24'h0000FF;
    tick();
    palWriteEn = 1'b0;
    #1;
    checks++;
    if (writeEn !== 1'b1 || dataOut !== expColor) begin
      failures++; $display("[TB] FAIL collision_data got we=%b data=%h exp we=1 data=%h", writeEn, dataOut, expColor);
    end
    tick();
    inValid = 1'b1;
    inIndex = 8'h20;
    tick();
    inValid = 1'b0;
    tick();
    #1;
    checks++;
    if (writeEn !== 1'b1 || dataOut !== 24'h0000FF) begin
      failures++; $display("[TB] FAIL collision_later got we=%b data=%h exp we=1 data=0000ff", writeEn, dataOut);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    write_pal(8'h30, 24'h123456);
    write_pal(8'h31, 24'h654321);
    fifoFull = 1'b1;
    inValid  = 1'b1;
    inIndex  = 8'h30;
    tick();
    inIndex = 8'h31;
    tick();
    inValid = 1'b0;
    reset   = 1'b1;
    #1;
    checks++;
    if (writeEn !== 1'b0 || inReady !== 1'b0) begin
      failures++; $display("[TB] FAIL rst_mid_full got we=%b rdy=%b exp we=0 rdy=0", writeEn, inReady);
    end
    tick();
    reset    = 1'b0;
    fifoFull = 1'b0;
    #1;
    checks++;
    if (writeEn !== 1'b0 || dataOut !== 24'h0 || pixelCount !== 16'd0 || inReady !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_mid_state got we=%b data=%h cnt=%0d rdy=%b exp we=0 data=000000 cnt=0 rdy=1",
               writeEn, dataOut, pixelCount, inReady);
    end
    tick();
    #1;
    checks++;
    if (writeEn !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_no_flush got=%b exp=0", writeEn); end
    inValid = 1'b1;
    inIndex = 8'h31;
    tick();
    inValid = 1'b0;
    tick();
    #1;
    checks++;
    if (writeEn !== 1'b1 || dataOut !== 24'h654321) begin
      failures++; $display("[TB] FAIL rst_mid_palette got we=%b data=%h exp we=1 data=654321", writeEn, dataOut);
    end
    tick();
  endtask

  task automatic test_count_wrap();
    int sent = 0;
    int wcount = 0;
    int c = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    while (wcount < 65537 && c < 70000) begin
      inValid = (sent < 65537);
      inIndex = 8'h05;
      #1;
      if (writeEn) begin
        if (wcount == 65535) begin
          checks++;
          if (pixelCount !== 16'hFFFF) begin failures++; $display("[TB] FAIL wrap_max got=%h exp=ffff", pixelCount); end
        end
        wcount++;
      end
      if (inValid && inReady) sent++;
      tick();
      c++;
    end
    inValid = 1'b0;
    #1;
    checks++;
    if (wcount !== 65537 || pixelCount !== 16'd1) begin
      failures++; $display("[TB] FAIL wrap_count got writes=%0d cnt=%0d exp writes=65537 cnt=1", wcount, pixelCount);
    end
  endtask

  initial begin
    reset      = 1'b1;
    inValid    = 1'b0;
    inIndex    = '0;
    palWriteEn = 1'b0;
    palAddr    = '0;
    palData    = '0;
    fifoFull   = 1'b0;
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_collision();
    test_reset_midstream();
    test_count_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
